// File: rtl/maze_pkg.sv
// maze_pkg: shared constants, FSM states and cell encodings for the maze store
package maze_pkg;
  localparam int N = 16;
  localparam int AW = $clog2(N);
  localparam int CNT_W = $clog2(N * N + 1);
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
  localparam logic CELL_FREE = 1'b0;
  localparam logic CELL_BLOCKED = 1'b1;
endpackage

// File: rtl/maze_plane.sv
// maze_plane: NxN bit plane with masked row write, combinational cell read and sync clear
module maze_plane #(
  parameter int N = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] wy,
  input  logic [N-1:0]  wmask,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] rx,
  input  logic [AW-1:0] ry,
  output logic          rq
);
  logic [N-1:0] mem [N];
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wy] <= (mem[wy] & ~wmask) | (wdata & wmask);
    end
  end
  assign rq = mem[ry][rx];
endmodule

// File: rtl/maze_memory_responder.sv
// maze_memory_responder: rat-facing maze store with row loader, base/overlay planes and restore
module maze_memory_responder
  import maze_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    x,
  input  logic [AW-1:0]    y,
  input  logic             rd,
  input  logic             wr,
  input  logic             d_in,
  output logic             d_out,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic [N-1:0]     ld_row,
  output logic             ld_ready,
  output logic             mem_ready,
  input  logic             restore,
  output logic [CNT_W-1:0] mark_cnt
);
  state_t state, state_n;
  logic [AW-1:0] rp;
  logic in_range, load_acc, enter_load, ov_clr, ov_we, b_q, o_q, rd_val;
  if ((1 << AW) == N) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = (32'(x) < N) && (32'(y) < N);
  end
  assign ld_ready   = state == LOAD;
  assign mem_ready  = state == READY;
  assign load_acc   = ld_valid && ld_ready;
  assign enter_load = ld_start && state != LOAD;
  assign ov_clr     = restore || enter_load;
  assign ov_we      = wr && mem_ready && in_range && !restore;
  // restore on the same edge hides the overlay so the read sees base only
  assign rd_val = (!mem_ready || !in_range) ? CELL_BLOCKED : (b_q | (o_q & !restore));
  always_comb begin
    state_n = state;
    state_n = (state == LOAD) ? ((ld_valid && rp == AW'(N - 1)) ? READY : LOAD)
                              : (ld_start ? LOAD : state);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rp       <= '0;
      d_out    <= CELL_FREE;
      mark_cnt <= '0;
    end else begin
      state    <= state_n;
      rp       <= enter_load ? '0 : load_acc ? rp + AW'(1) : rp;
      d_out    <= rd ? rd_val : d_out;
      mark_cnt <= ov_clr ? '0
                : (ov_we && o_q != d_in) ? (d_in ? mark_cnt + CNT_W'(1) : mark_cnt - CNT_W'(1))
                : mark_cnt;
    end
  end
  maze_plane #(.N(N), .AW(AW)) u_base (
    .clk(clk), .rst(rst), .clr(1'b0), .we(load_acc), .wy(rp),
    .wmask({N{1'b1}}), .wdata(ld_row), .rx(x), .ry(y), .rq(b_q)
  );
  maze_plane #(.N(N), .AW(AW)) u_overlay (
    .clk(clk), .rst(rst), .clr(ov_clr), .we(ov_we), .wy(y),
    .wmask(N'(1) << x), .wdata({N{d_in}}), .rx(x), .ry(y), .rq(o_q)
  );
endmodule

// File: tb/tb_maze_memory_responder.sv
// tb_maze_memory_responder: directed scoreboard bench for the maze store
module tb_maze_memory_responder;
  logic clk = 0, rst = 0, rd = 0, wr = 0, d_in = 0, d_out;
  logic [3:0] x = 0, y = 0;
  logic ld_start = 0, ld_valid = 0, ld_ready, mem_ready, restore = 0;
  logic [15:0] ld_row = 0;
  logic [8:0] mark_cnt;
  int vectors = 0, miscompares = 0;
  logic exp_q[$];
  logic [15:0] mb[16], mo[16], ld_rows[16];
  int mcnt = 0, nr;
  bit mrdy = 0;
  logic last;

  always #5 clk = ~clk;

  maze_memory_responder dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .rd(rd), .wr(wr), .d_in(d_in), .d_out(d_out),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_row(ld_row), .ld_ready(ld_ready),
    .mem_ready(mem_ready), .restore(restore), .mark_cnt(mark_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear;
    for (int i = 0; i < 16; i++) mo[i] = '0;
    mcnt = 0;
  endtask

  task automatic access(input logic r, input logic w, input int cx, input int cy,
                        input logic d, input logic rs = 1'b0);
    rd = r; wr = w; x = 4'(cx); y = 4'(cy); d_in = d; restore = rs;
    if (r) exp_q.push_back(!mrdy ? 1'b1 : rs ? mb[cy][cx] : (mb[cy][cx] | mo[cy][cx]));
    tick;
    if (rs) model_clear();
    else if (w && mrdy && mo[cy][cx] != d) begin
      mo[cy][cx] = d;
      mcnt += d ? 1 : -1;
    end
    rd = 0; wr = 0; restore = 0;
    if (r) chk($sformatf("rd(%0d,%0d)", cx, cy), 32'(d_out), 32'(exp_q.pop_front()));
    chk("mark_cnt", 32'(mark_cnt), 32'(mcnt));
  endtask

  task automatic load(input int rows);
    ld_start = 1;
    tick;
    ld_start = 0;
    model_clear();
    mrdy = 0;
    chk("ld_ready_enter", 32'(ld_ready), 1);
    chk("mem_ready_loading", 32'(mem_ready), 0);
    chk("cnt_load", 32'(mark_cnt), 0);
    for (int r = 0; r < rows; r++) begin
      ld_valid = 1;
      ld_row = ld_rows[r];
      tick;
      mb[r] = ld_rows[r];
    end
    ld_valid = 0;
    if (rows == 16) begin
      chk("mem_ready_up", 32'(mem_ready), 1);
      mrdy = 1;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mb[i] = '0; mo[i] = '0; end
    rst = 1;
    tick; tick;
    rst = 0;
    chk("rst_d_out", 32'(d_out), 0);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    chk("rst_cnt", 32'(mark_cnt), 0);
    // before any load: reads are blocked, writes ignored
    access(1, 0, 2, 2, 0);
    access(0, 1, 2, 2, 1);
    // basic load and read
    for (int r = 0; r < 16; r++) ld_rows[r] = (r == 0) ? 16'h0001 : 16'h0000;
    load(16);
    access(1, 0, 0, 0, 0);
    access(1, 0, 1, 0, 0);
    last = d_out;
    tick;
    chk("d_out_hold", 32'(d_out), 32'(last));
    // overlay write / read / clear
    access(0, 1, 5, 7, 1);
    access(1, 0, 5, 7, 0);
    access(0, 1, 5, 7, 0);
    access(1, 0, 5, 7, 0);
    // read-before-write
    access(1, 1, 3, 3, 1);
    access(1, 0, 3, 3, 0);
    // restore
    access(0, 1, 9, 9, 1);
    access(0, 1, 15, 15, 1);
    access(0, 1, 0, 15, 1);
    access(1, 0, 15, 0, 0, 1);
    access(1, 0, 3, 3, 0);
    access(1, 0, 9, 9, 0);
    access(1, 0, 0, 0, 0);
    access(0, 1, 4, 4, 1);
    access(1, 1, 4, 4, 1, 1);
    access(1, 0, 4, 4, 0);
    // reset in the middle of a load
    for (int r = 0; r < 16; r++) ld_rows[r] = 16'hFFFF;
    load(9);
    rst = 1;
    tick;
    rst = 0;
    for (int i = 0; i < 16; i++) mb[i] = '0;
    model_clear();
    mrdy = 0;
    chk("midrst_ld_ready", 32'(ld_ready), 0);
    chk("midrst_mem_ready", 32'(mem_ready), 0);
    chk("midrst_cnt", 32'(mark_cnt), 0);
    for (int r = 0; r < 16; r++) ld_rows[r] = 16'h0001 << r;
    load(16);
    access(1, 0, 3, 3, 0);
    access(1, 0, 4, 3, 0);
    access(1, 0, 0, 8, 0);
    // rat-style walk over a loaded maze, marking free cells
    for (int r = 0; r < 16; r++) ld_rows[r] = (r < 15) ? 16'hFF00 : 16'h0000;
    load(16);
    nr = 0;
    for (int yy = 0; yy < 2; yy++)
      for (int xx = 6; xx < 10; xx++) begin
        chk("rat_gate", 32'(mem_ready), 1);
        access(1, 0, xx, yy, 0);
        if (!(mb[yy][xx] | mo[yy][xx])) begin
          access(0, 1, xx, yy, 1);
          nr++;
        end
      end
    chk("rat_marks", 32'(mark_cnt), 32'(nr));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
